uart_rx: RTL

UART receiver that recovers 8-bit frames from an asynchronous serial line at a fixed baud rate derived from the system clock. It generates its own oversampling tick internally, so it needs no external divided clock. It delivers each received byte through a one-entry valid/ready holding register and reports overrun and framing errors. It is the receive end of the serial link whose transmit side is clocked from the team's baud-rate divider.

---
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver (8E1 when UART_RX_PARITY_EN is defined) with an internal oversampling tick; results register 1 cycle after the stop-bit sample.
// One-entry valid/ready output register: a byte completing while it is still full and not being consumed is dropped with an overrun pulse.
module uart_rx #(
  parameter int IN_FREQ    = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int DIV = IN_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t        state;
  state_t        state_d;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] samp_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bad;
  logic          half_hit;
  logic          full_hit;
  logic          cnt_clr;
  logic          samp_clr;
  logic          shift_en;
  logic          stop_hit;
  logic          good;
  logic          load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (cnt_clr || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  // Sample counter: ticks since the last bit sample (or since the start edge).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_cnt <= '0;
    end else if (samp_clr) begin
      samp_cnt <= '0;
    end else if (tick) begin
      samp_cnt <= (samp_cnt == FULL_LAST) ? '0 : samp_cnt + SW'(1);
    end
  end

  assign half_hit = tick && (samp_cnt == HALF_LAST);
  assign full_hit = tick && (samp_cnt == FULL_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_hit;
`endif

  always_comb begin
    state_d  = state;
    cnt_clr  = 1'b0;
    samp_clr = 1'b0;
    shift_en = 1'b0;
    stop_hit = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_hit  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          cnt_clr  = 1'b1;
          samp_clr = 1'b1;
        end
      end
      START: begin
        if (half_hit) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            samp_clr = 1'b1;
          end
        end
      end
      DATA: begin
        if (full_hit) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_hit) begin
          par_hit = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (full_hit) begin
          stop_hit = 1'b1;
          state_d  = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      if (state == START) begin
        bit_cnt <= 3'd0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[7:1]};
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad <= 1'b0;
    end else if (par_hit) begin
      par_bad <= rx_s ^ (^shreg);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_hit && par_bad;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign good = stop_hit && rx_s && !par_bad;
  assign load = good && (!data_valid || data_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_hit && !rx_s;
      overrun   <= good && data_valid && !data_ready;
      if (load) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
